// File: rtl/alu_out_stage.sv
// Registered ALU output stage with a two-entry skid buffer and valid/ready handshake.
// Optional saturating overflow counter is built when ALU_OUT_OVF_CNT_EN is defined.
module alu_out_stage #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [N-1:0] in_result_i,
   input  logic         in_carry_i,
   input  logic         in_ovf_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [N-1:0] out_result_o,
   output logic         out_z_o,
   output logic         out_n_o,
   output logic         out_c_o,
   output logic         out_v_o,
   output logic [7:0]   ovf_count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [N-1:0] result;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t newEntry;
   logic   accept;
   logic   deliver;

   // Flags are derived once at capture and travel with the result.
   always_comb begin
      newEntry.result = in_result_i;
      newEntry.z      = (in_result_i == '0);
      newEntry.n      = in_result_i[N-1];
      newEntry.c      = in_carry_i;
      newEntry.v      = in_ovf_i;
   end

   assign in_ready_o  = (state_q != TWO);
   assign out_valid_o = (state_q != EMPTY);
   assign accept      = in_valid_i && in_ready_o;
   assign deliver     = out_valid_o && out_ready_i;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               head_d  = newEntry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               head_d = newEntry;
            end else if (accept) begin
               skid_d  = newEntry;
               state_d = TWO;
            end else if (deliver) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (deliver) begin
               head_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign out_result_o = head_q.result;
   assign out_z_o      = head_q.z;
   assign out_n_o      = head_q.n;
   assign out_c_o      = head_q.c;
   assign out_v_o      = head_q.v;

`ifdef ALU_OUT_OVF_CNT_EN
   logic [7:0] ovfCount_q, ovfCount_d;

   // Counts accepted overflowed results, sticking at 255.
   always_comb begin
      ovfCount_d = ovfCount_q;
      if (accept && in_ovf_i && (ovfCount_q != 8'hFF)) begin
         ovfCount_d = ovfCount_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ovfCount_q <= '0;
      end else begin
         ovfCount_q <= ovfCount_d;
      end
   end

   assign ovf_count_o = ovfCount_q;
`else
   assign ovf_count_o = '0;
`endif

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: queue scoreboard of expected results and flags,
// plus a small occupancy model for out_valid/in_ready and the overflow counter.
module tb_alu_out_stage;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         inValid;
   logic         inReady;
   logic [N-1:0] inResult;
   logic         inCarry;
   logic         inOvf;
   logic         outValid;
   logic         outReady;
   logic [N-1:0] outResult;
   logic         outZ;
   logic         outN;
   logic         outC;
   logic         outV;
   logic [7:0]   ovfCount;

   alu_out_stage #(.N(N)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (inValid),
      .in_ready_o   (inReady),
      .in_result_i  (inResult),
      .in_carry_i   (inCarry),
      .in_ovf_i     (inOvf),
      .out_valid_o  (outValid),
      .out_ready_i  (outReady),
      .out_result_o (outResult),
      .out_z_o      (outZ),
      .out_n_o      (outN),
      .out_c_o      (outC),
      .out_v_o      (outV),
      .ovf_count_o  (ovfCount)
   );

   int total = 0;
   int bad = 0;
   int delivered = 0;
   int ovfModel = 0;
   bit seenReset = 0;
   logic [N+3:0] expQ[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Runs at the falling edge: compares outputs against the model, then advances the model
   // with the handshakes that will happen at the coming rising edge.
   task automatic sampleCycle();
      logic [N+3:0] e;
      bit acceptM;
      bit deliverM;
      if (seenReset) begin
         checkOutput("out_valid", {31'd0, outValid}, {31'd0, expQ.size() > 0});
         checkOutput("in_ready", {31'd0, inReady}, {31'd0, expQ.size() < 2});
         checkOutput("ovf_count", {24'd0, ovfCount}, ovfModel);
      end
      if (!rst_n) begin
         expQ.delete();
         ovfModel = 0;
         seenReset = 1;
         return;
      end
      if (!seenReset) return;
      acceptM  = inValid && (expQ.size() < 2);
      deliverM = (expQ.size() > 0) && outReady;
      if (deliverM) begin
         e = expQ.pop_front();
         delivered++;
         checkOutput("out_result", {28'd0, outResult}, {28'd0, e[N+3:4]});
         checkOutput("out_flags", {28'd0, outZ, outN, outC, outV}, {28'd0, e[3:0]});
      end
      if (acceptM) begin
         expQ.push_back({inResult, inResult == '0, inResult[N-1], inCarry, inOvf});
`ifdef ALU_OUT_OVF_CNT_EN
         if (inOvf && ovfModel < 255) ovfModel++;
`endif
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [N-1:0] r, input logic c,
                                input logic o, input logic ordy);
      inValid  = v;
      inResult = r;
      inCarry  = c;
      inOvf    = o;
      outReady = ordy;
      @(negedge clk);
      sampleCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int startCount;
      rst_n    = 1'b0;
      inValid  = 1'b1;
      inResult = 4'b1111;
      inCarry  = 1'b1;
      inOvf    = 1'b1;
      outReady = 1'b1;

      // Reset with in_valid held high.
      applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
      rst_n = 1'b1;
      checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("rst_out_result", {28'd0, outResult}, 32'd0);
      checkOutput("rst_flags", {28'd0, outZ, outN, outC, outV}, 32'd0);
      checkOutput("rst_ovf_count", {24'd0, ovfCount}, 32'd0);

      // Flag derivation.
      applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

      // Backpressure: third input must be held until space opens.
      applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_in_ready_low", {31'd0, inReady}, 32'd0);
      applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_drained", expQ.size(), 32'd0);

      // Streaming 0..7 back to back.
      startCount = delivered;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, i[N-1:0], i[0], 1'b0, 1'b1);
      end
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      checkOutput("stream_count", delivered - startCount, 32'd8);

      // Reach TWO, then reset: buffered values must vanish.
      applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
      checkOutput("two_in_ready", {31'd0, inReady}, 32'd0);
      rst_n = 1'b0;
      applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      checkOutput("midrst_out_valid", {31'd0, outValid}, 32'd0);
      startCount = delivered;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("midrst_no_delivery", delivered - startCount, 32'd0);
      if (outValid) checkOutput("midrst_ghost", {28'd0, outResult}, 32'hFFFF_FFFF);

      // 300 overflowed accepts.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, i[N-1:0], 1'b0, 1'b1, 1'b1);
      end
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
`ifdef ALU_OUT_OVF_CNT_EN
      checkOutput("ovf_saturated", {24'd0, ovfCount}, 32'd255);
`else
      checkOutput("ovf_tied_zero", {24'd0, ovfCount}, 32'd0);
`endif

      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      checkOutput("final_drain", expQ.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_out_stage.md
# alu_out_stage

Registered output stage placed directly downstream of the combinational ALU (add/sub/logic/shift units, including the logical right shifter). Each cycle it captures the selected ALU result with its carry/overflow indications, derives the zero and negative flags, and presents result and flags to the consumer through a valid/ready handshake. A two-entry skid buffer keeps full throughput under backpressure, and the registered `in_ready` breaks the combinational path from the consumer back into the ALU.

## Interface
- `N`, default 4: ALU data width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  ALU result valid this cycle.
- `in_ready`  output  1  stage can accept; registered.
- `in_result`  input  N  ALU result.
- `in_carry`  input  1  carry-out / shifted-out bit from the ALU.
- `in_ovf`  input  1  signed overflow from the ALU.
- `out_valid`  output  1  `out_result` and flags hold valid data.
- `out_ready`  input  1  consumer accepts this cycle.
- `out_result`  output  N  buffered result.
- `out_z`, `out_n`, `out_c`, `out_v`  output  1 each  zero, negative, carry and overflow flags.
- `ovf_count`  output  8  number of overflowed results accepted (see Configuration).

## Operation
- Accept on `in_valid && in_ready`. Deliver on `out_valid && out_ready`.
- Flags are computed at capture and stored with the result:
  - `Z = (in_result == 0)`
  - `Nf = in_result[N-1]`
  - `C = in_carry`
  - `V = in_ovf`
- Storage is a head register (drives the outputs) plus a skid register. States:
  - EMPTY: `out_valid=0`, `in_ready=1`. An accept loads head and moves to ONE.
  - ONE: `out_valid=1`, `in_ready=1`.
    - Accept and deliver in the same cycle: head is reloaded, state stays ONE.
    - Accept only: skid is loaded, go to TWO.
    - Deliver only: go to EMPTY.
  - TWO: `out_valid=1`, `in_ready=0`. A deliver moves skid into head and goes to ONE. `in_valid` is ignored in TWO.
- Order is strictly FIFO. Nothing is dropped or duplicated.
- Reset values: state EMPTY, `out_valid=0`, `in_ready=1`, `out_result=0`, all flags 0, `ovf_count=0`.
- Reset asserted mid-operation discards all buffered entries on that edge. Handshakes in the same cycle are ignored.
- Outputs stay stable while `out_valid && !out_ready`.

## Timing
- Latency: a result accepted at edge k appears on `out_*` after edge k (one cycle), when the buffer was EMPTY or head was delivered at the same edge.
- Throughput: 1 result per cycle while `out_ready=1`.
- `in_ready` is a pure function of state, so no combinational path runs from `out_ready` to `in_ready`.
- `in_ready` drops the cycle after the second entry fills. With `out_ready` held high, it rises one cycle after the first deliver from TWO.
- The upstream ALU must hold `in_*` stable while `in_valid && !in_ready`.

## Configuration
- Macro `ALU_OUT_OVF_CNT_EN`.
  - Defined: `ovf_count` increments by 1 on every accept with `in_ovf=1`. It saturates at 255 and clears only on reset.
  - Undefined: no counter logic is built and `ovf_count` is tied to 0.
- The flag and handshake behaviour is identical either way.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `in_valid=1` -> `out_valid=0`, `in_ready=1`, `out_result=0000`, flags 0, `ovf_count=0`.
- Flags, with `out_ready=1`:
  - `in_result=0001`, `in_carry=0` -> next cycle `out_result=0001`, Z=0, N=0, C=0.
  - `in_result=0000`, `in_carry=1` -> Z=1, C=1.
  - `in_result=1000` -> N=1.
- Backpressure: `out_ready=0`, send 0010 then 0011 -> `in_ready=0` after the second. A third input 0100 is held. Raise `out_ready` -> outputs 0010, 0011, 0100 in order with no gaps or duplicates.
- Streaming: `out_ready=1`, 8 back-to-back inputs 0..7 -> `out_valid` stays high for 8 consecutive cycles with values 0..7, and `in_ready` never drops.
- Mid-operation reset: reach TWO holding 0101 and 0110, then pulse `rst_n=0` for one cycle -> `out_valid=0` next cycle and neither value is ever delivered.
- With `ALU_OUT_OVF_CNT_EN` defined: 300 accepts with `in_ovf=1` -> `ovf_count=255`. Without it -> `ovf_count=0` throughout.
